// File: rtl/id_stage.sv
// id_stage: pipelined MIPS-subset decode stage with register file, branch/jump targets and hazard stalls.
// Optional ID_WB_BYPASS_EN forwards same-cycle write-back data onto the read ports.
module id_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic        wwreg,
  input  logic [4:0]  wrn,
  input  logic [31:0] wdata,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  ern,
  input  logic        mwreg,
  input  logic [4:0]  mrn,
  output logic [1:0]  pcsource,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic        wpcir,
  output logic [31:0] da,
  output logic [31:0] db,
  output logic [31:0] imm,
  output logic [4:0]  rn,
  output logic        wreg,
  output logic        m2reg,
  output logic        wmem,
  output logic        aluimm,
  output logic [2:0]  aluc
);
  logic [31:0] dpc4, dinst, sext;
  logic [31:0] regs [32];
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic i_add, i_sub, i_and, i_or, i_addi, i_andi, i_ori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j;
  logic r_type, load_use, br_stall, stall;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      dpc4  <= '0;
      dinst <= '0;
    end else if (wpcir) begin
      dpc4  <= pc4;
      dinst <= inst;
    end
  // regs[0] is never written, so reading it always yields zero
  always_ff @(posedge clk or negedge clrn)
    if (!clrn)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wwreg && wrn != 5'd0)
      regs[wrn] <= wdata;
  assign op = dinst[31:26];
  assign rs = dinst[25:21];
  assign rt = dinst[20:16];
  assign rd = dinst[15:11];
  assign fn = dinst[5:0];
  assign i_add  = op == 6'h00 && fn == 6'h20;
  assign i_sub  = op == 6'h00 && fn == 6'h22;
  assign i_and  = op == 6'h00 && fn == 6'h24;
  assign i_or   = op == 6'h00 && fn == 6'h25;
  assign i_addi = op == 6'h08;
  assign i_andi = op == 6'h0C;
  assign i_ori  = op == 6'h0D;
  assign i_lui  = op == 6'h0F;
  assign i_lw   = op == 6'h23;
  assign i_sw   = op == 6'h2B;
  assign i_beq  = op == 6'h04;
  assign i_bne  = op == 6'h05;
  assign i_j    = op == 6'h02;
  assign r_type = i_add | i_sub | i_and | i_or;
`ifdef ID_WB_BYPASS_EN
  assign da = (wwreg && wrn != 5'd0 && wrn == rs) ? wdata : regs[rs];
  assign db = (wwreg && wrn != 5'd0 && wrn == rt) ? wdata : regs[rt];
`else
  assign da = regs[rs];
  assign db = regs[rt];
`endif
  assign load_use = ewreg && em2reg && ern != 5'd0 &&
                    (ern == rs || ((r_type | i_sw | i_beq | i_bne) && ern == rt));
  assign br_stall = (i_beq | i_bne) &&
                    ((ewreg && ern != 5'd0 && (ern == rs || ern == rt)) ||
                     (mwreg && mrn != 5'd0 && (mrn == rs || mrn == rt)));
  assign stall  = load_use | br_stall;
  assign wpcir  = ~stall;
  assign sext   = {{16{dinst[15]}}, dinst[15:0]};
  assign imm    = (i_andi | i_ori) ? {16'h0, dinst[15:0]} : sext;
  assign bpc    = dpc4 + {sext[29:0], 2'b00};
  assign jpc    = {dpc4[31:28], dinst[25:0], 2'b00};
  assign rn     = r_type ? rd : rt;
  assign wreg   = ~stall & (r_type | i_addi | i_andi | i_ori | i_lui | i_lw);
  assign wmem   = ~stall & i_sw;
  assign m2reg  = i_lw;
  assign aluimm = i_addi | i_andi | i_ori | i_lui | i_lw | i_sw;
  assign aluc   = i_sub ? 3'd1 : (i_and | i_andi) ? 3'd2 : (i_or | i_ori) ? 3'd3 : i_lui ? 3'd4 : 3'd0;
  assign pcsource = stall ? 2'b00 :
                    ((i_beq && da == db) || (i_bne && da != db)) ? 2'b01 :
                    i_j ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector self-checking bench for id_stage.
module tb_id_stage;
  logic        clk = 0, clrn = 0;
  logic [31:0] pc4 = 0, inst = 0, wdata = 0;
  logic        wwreg = 0, ewreg = 0, em2reg = 0, mwreg = 0;
  logic [4:0]  wrn = 0, ern = 0, mrn = 0;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, da, db, imm;
  logic        wpcir, wreg, m2reg, wmem, aluimm;
  logic [4:0]  rn;
  logic [2:0]  aluc;
  int total = 0, bad = 0;

  id_stage dut (
    .clk(clk), .clrn(clrn), .pc4(pc4), .inst(inst),
    .wwreg(wwreg), .wrn(wrn), .wdata(wdata),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mrn(mrn),
    .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .wpcir(wpcir),
    .da(da), .db(db), .imm(imm), .rn(rn), .wreg(wreg), .m2reg(m2reg),
    .wmem(wmem), .aluimm(aluimm), .aluc(aluc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wwreg = 1; wrn = a; wdata = d;
    tick();
    wwreg = 0; wrn = 0;
  endtask

  task automatic load(input logic [31:0] p, input logic [31:0] i);
    pc4 = p; inst = i;
    tick();
  endtask

  initial begin
    inst = 32'hDEADBEEF; pc4 = 32'h1234;
    tick();
    chk("rst_wreg", {31'b0, wreg}, 0);
    chk("rst_wmem", {31'b0, wmem}, 0);
    chk("rst_pcsrc", {30'b0, pcsource}, 0);
    chk("rst_wpcir", {31'b0, wpcir}, 1);
    chk("rst_da", da, 0);
    chk("rst_db", db, 0);
    clrn = 1; inst = 0; pc4 = 0;
    tick();
    chk("nop_wreg", {31'b0, wreg}, 0);

    wr(1, 5); wr(2, 3);
    load(32'h4, 32'h00221820);
    chk("add_da", da, 5);
    chk("add_db", db, 3);
    chk("add_aluc", {29'b0, aluc}, 0);
    chk("add_rn", {27'b0, rn}, 3);
    chk("add_wreg", {31'b0, wreg}, 1);
    chk("add_aluimm", {31'b0, aluimm}, 0);

    load(32'h4, 32'h00221822);
    chk("sub_aluc", {29'b0, aluc}, 1);
    load(32'h4, 32'h00221825);
    chk("or_aluc", {29'b0, aluc}, 3);

    wr(1, 7); wr(2, 7);
    load(32'h100, 32'h10220004);
    chk("beq_pcsrc", {30'b0, pcsource}, 1);
    chk("beq_bpc", bpc, 32'h110);
    chk("beq_wreg", {31'b0, wreg}, 0);
    wr(2, 8);
    chk("beq_nt_pcsrc", {30'b0, pcsource}, 0);

    load(32'h40000004, 32'h08000010);
    chk("j_pcsrc", {30'b0, pcsource}, 2);
    chk("j_jpc", jpc, 32'h40000040);

    load(32'h4, 32'h34228000);
    chk("ori_imm", imm, 32'h00008000);
    chk("ori_aluc", {29'b0, aluc}, 3);
    chk("ori_aluimm", {31'b0, aluimm}, 1);
    chk("ori_rn", {27'b0, rn}, 2);
    load(32'h4, 32'h3022FFFC);
    chk("andi_imm", imm, 32'h0000FFFC);
    chk("andi_aluc", {29'b0, aluc}, 2);
    load(32'h4, 32'h2022FFFC);
    chk("addi_imm", imm, 32'hFFFFFFFC);
    chk("addi_aluc", {29'b0, aluc}, 0);
    load(32'h4, 32'h8C240008);
    chk("lw_m2reg", {31'b0, m2reg}, 1);
    chk("lw_wreg", {31'b0, wreg}, 1);
    chk("lw_rn", {27'b0, rn}, 4);
    load(32'h4, 32'hAC240008);
    chk("sw_wmem", {31'b0, wmem}, 1);
    chk("sw_wreg", {31'b0, wreg}, 0);
    load(32'h4, 32'h3C041234);
    chk("lui_aluc", {29'b0, aluc}, 4);
    chk("lui_imm", imm, 32'h00001234);
    load(32'h4, 32'hFC000000);
    chk("bad_wreg", {31'b0, wreg}, 0);
    chk("bad_pcsrc", {30'b0, pcsource}, 0);

    load(32'h200, 32'h00221820);
    ewreg = 1; em2reg = 1; ern = 1;
    pc4 = 32'h300; inst = 32'h08000010;
    #1;
    chk("lu_wpcir", {31'b0, wpcir}, 0);
    chk("lu_wreg", {31'b0, wreg}, 0);
    tick();
    chk("lu_hold_rn", {27'b0, rn}, 3);
    chk("lu_hold_da", da, 7);
    ern = 2;
    #1;
    chk("lu_rt_wpcir", {31'b0, wpcir}, 0);
    ewreg = 0; em2reg = 0; ern = 0;
    #1;
    chk("lu_rel_wpcir", {31'b0, wpcir}, 1);
    chk("lu_rel_wreg", {31'b0, wreg}, 1);
    tick();
    chk("lu_next_pcsrc", {30'b0, pcsource}, 2);
    chk("lu_next_jpc", jpc, 32'h00000040);

    load(32'h100, 32'h14220004);
    chk("bne_pcsrc", {30'b0, pcsource}, 1);
    mwreg = 1; mrn = 2;
    #1;
    chk("bs_wpcir", {31'b0, wpcir}, 0);
    chk("bs_pcsrc", {30'b0, pcsource}, 0);
    mwreg = 0; ewreg = 1; ern = 1;
    #1;
    chk("bs_ex_wpcir", {31'b0, wpcir}, 0);
    mwreg = 1; mrn = 2;
    clrn = 0;
    #1;
    chk("rst_stall_wpcir", {31'b0, wpcir}, 1);
    chk("rst_stall_pcsrc", {30'b0, pcsource}, 0);
    chk("rst_regs_da", da, 0);
    mwreg = 0; mrn = 0; ewreg = 0; ern = 0;
    tick();
    clrn = 1;

    wr(1, 32'h11);
    load(32'h4, 32'h00221820);
    wwreg = 1; wrn = 1; wdata = 32'h55;
    #1;
`ifdef ID_WB_BYPASS_EN
    chk("byp_da", da, 32'h55);
`else
    chk("byp_da", da, 32'h11);
`endif
    tick();
    wwreg = 0; wrn = 0;
    #1;
    chk("byp_next_da", da, 32'h55);
    wwreg = 1; wrn = 0; wdata = 32'h99;
    tick();
    wwreg = 0;
    load(32'h4, 32'h00001820);
    chk("r0_da", da, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port clrn, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have inputs pc4 (32) and inst (32), the PC+4 and instruction fetched by the IF stage.
REQ-004 SHALL have write-back inputs wwreg (1), wrn (5), wdata (32): register-file write enable, address, data.
REQ-005 SHALL have hazard inputs ewreg (1), em2reg (1), ern (5), mwreg (1), mrn (5): EX and MEM stage destination info.
REQ-006 SHALL have outputs pcsource (2), bpc (32), jpc (32), wpcir (1) to the IF stage; wpcir=1 means IF may advance PC.
REQ-007 SHALL have outputs da (32), db (32), imm (32), rn (5), wreg, m2reg, wmem, aluimm (1 each), aluc (3) to the EX stage.

Function
REQ-008 SHALL latch pc4/inst into internal dpc4/dinst on each rising clk when wpcir=1; hold them when wpcir=0.
REQ-009 SHALL hold a 32x32 register file; r0 reads 0 and ignores writes; write on rising clk when wwreg=1 and wrn!=0.
REQ-010 SHALL decode dinst: R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or; opcodes 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
REQ-011 SHALL treat any other encoding, including 0x00000000, as nop: wreg=wmem=0, pcsource=00.
REQ-012 SHALL drive aluc 000 add/addi/lw/sw, 001 sub, 010 and/andi, 011 or/ori, 100 lui; aluimm=1 for addi/andi/ori/lui/lw/sw.
REQ-013 SHALL drive imm as zero-extended imm16 for andi/ori, sign-extended imm16 otherwise.
REQ-014 SHALL drive rn=rd for R-type, rt for I-type writes; wreg=1 for R-type/addi/andi/ori/lui/lw; m2reg=1 for lw; wmem=1 for sw.
REQ-015 SHALL compute bpc = dpc4 + (sign-extended imm16 << 2) mod 2^32, and jpc = {dpc4[31:28], dinst[25:0], 00}.
REQ-016 SHALL drive pcsource 01 for beq with da==db or bne with da!=db, 10 for j, 00 otherwise; 11 never driven.
REQ-017 SHALL execute the instruction in the branch delay slot; no IF/ID flush on taken branch or jump.
REQ-018 SHALL assert load-use stall when ewreg=1, em2reg=1, ern!=0 and ern equals rs, or rt for R-type/sw/beq/bne.
REQ-019 SHALL assert branch stall when dinst is beq/bne and (ewreg=1, ern!=0) or (mwreg=1, mrn!=0) with that rn equal to rs or rt.
REQ-020 SHALL, while any stall holds, drive wpcir=0, wreg=0, wmem=0, pcsource=00 (bubble to EX; IF holds PC).
REQ-021 SHALL produce all EX/IF outputs combinationally from dinst/dpc4/register file within the same cycle (ID latency one cycle after IF).

Reset
REQ-022 SHALL, while clrn=0, clear dpc4 and dinst to 0 asynchronously, making outputs decode as nop with wpcir=1, pcsource=00.
REQ-023 SHALL clear all 31 writable registers to 0 on reset; reset mid-stall SHALL clear the stall immediately.

Configuration
REQ-024 SHALL, when macro ID_WB_BYPASS_EN is defined, return wdata on da/db when wwreg=1 and wrn equals the read address (nonzero) in the same cycle.
REQ-025 SHALL, when ID_WB_BYPASS_EN is undefined, return the pre-write register value in that case; the new value appears the next cycle.

Verification
REQ-026 Reset: clrn=0 then 1 -> dinst=0, wreg=0, wmem=0, pcsource=00, wpcir=1, da=db=0.
REQ-027 ALU decode: r1=5, r2=3, inst add r3,r1,r2 (0x00221820) -> da=5, db=3, aluc=000, rn=3, wreg=1, aluimm=0.
REQ-028 Branch: dpc4=0x100, r1=r2=7, beq r1,r2,+4 (0x10220004) -> pcsource=01, bpc=0x110; with r2=8 -> pcsource=00.
REQ-029 Jump: dpc4=0x40000004, j 0x10 (0x08000010) -> pcsource=10, jpc=0x40000040.
REQ-030 Load-use: ewreg=1, em2reg=1, ern=1, dinst add r3,r1,r2 -> wpcir=0, wreg=0 for one cycle; dinst held; next cycle ern=0 -> wpcir=1.
REQ-031 Bypass: wwreg=1, wrn=1, wdata=0x55 while dinst reads r1 -> da=0x55 with ID_WB_BYPASS_EN, old r1 value without it.
